// File: rtl/sd_sector_server_pkg.sv
// Shared SD sector-server definitions: sector geometry, FSM state encoding and
// a helper that tells which states belong to an active transfer.
package sd_sector_server_pkg;

  localparam int SD_ADDR_W       = 9;
  localparam int SD_SECTOR_BYTES = 512;

  typedef logic [2:0] sd_state_t;

  localparam sd_state_t ST_IDLE    = 3'd0;
  localparam sd_state_t ST_CMD     = 3'd1;
  localparam sd_state_t ST_RD_DATA = 3'd2;
  localparam sd_state_t ST_WR_ADDR = 3'd3;
  localparam sd_state_t ST_WR_CAP  = 3'd4;
  localparam sd_state_t ST_WR_SEND = 3'd5;
  localparam sd_state_t ST_DONE    = 3'd6;

  function automatic logic sd_state_active(input sd_state_t st);
    logic act;
    case (st)
      ST_CMD, ST_RD_DATA, ST_WR_ADDR, ST_WR_CAP, ST_WR_SEND: act = 1'b1;
      default:                                              act = 1'b0;
    endcase
    return act;
  endfunction

endpackage

// File: rtl/sd_sector_server.sv
// Serves one sector per core request: forwards the command to the host, then
// streams sector bytes host->core buffer (read) or core buffer->host (write).
module sd_sector_server
  import sd_sector_server_pkg::*;
#(
  parameter int ADDR_W = SD_ADDR_W
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic [31:0]       sd_lba,
  input  logic              sd_rd,
  input  logic              sd_wr,
  output logic              sd_ack,
  output logic [ADDR_W-1:0] sd_buff_addr,
  output logic [7:0]        sd_buff_dout,
  input  logic [7:0]        sd_buff_din,
  output logic              sd_buff_wr,
  output logic              host_cmd_valid,
  input  logic              host_cmd_ready,
  output logic [31:0]       host_cmd_lba,
  output logic              host_cmd_write,
  input  logic              host_rd_valid,
  input  logic [7:0]        host_rd_data,
  output logic              host_rd_ready,
  output logic              host_wr_valid,
  output logic [7:0]        host_wr_data,
  input  logic              host_wr_ready
);

  localparam int CNT_W = ADDR_W + 1;

  sd_state_t          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sd_ack_q, sd_ack_d;
  logic [ADDR_W-1:0]  sd_buff_addr_q, sd_buff_addr_d;
  logic [7:0]         sd_buff_dout_q, sd_buff_dout_d;
  logic               sd_buff_wr_q, sd_buff_wr_d;
  logic               host_cmd_valid_q, host_cmd_valid_d;
  logic [31:0]        host_cmd_lba_q, host_cmd_lba_d;
  logic               host_cmd_write_q, host_cmd_write_d;
  logic               host_rd_ready_q, host_rd_ready_d;
  logic               host_wr_valid_q, host_wr_valid_d;
  logic [7:0]         host_wr_data_q, host_wr_data_d;

  // Next-state, counter and datapath; every output is registered from state_d.
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    sd_buff_addr_d   = sd_buff_addr_q;
    sd_buff_dout_d   = sd_buff_dout_q;
    sd_buff_wr_d     = 1'b0;
    host_cmd_lba_d   = host_cmd_lba_q;
    host_cmd_write_d = host_cmd_write_q;
    host_wr_data_d   = host_wr_data_q;

    case (state_q)
      ST_IDLE: begin
        if (sd_rd) begin
          host_cmd_lba_d   = sd_lba;
          host_cmd_write_d = 1'b0;
          state_d          = ST_CMD;
        end else if (sd_wr) begin
          host_cmd_lba_d   = sd_lba;
          host_cmd_write_d = 1'b1;
          state_d          = ST_CMD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CMD: begin
        if (host_cmd_valid_q && host_cmd_ready) begin
          cnt_d   = '0;
          state_d = host_cmd_write_q ? ST_WR_ADDR : ST_RD_DATA;
        end else begin
          state_d = ST_CMD;
        end
      end
      ST_RD_DATA: begin
        // Terminal count: the last strobe is on the bus this cycle, ack still high.
        if (cnt_q[ADDR_W]) begin
          state_d = ST_DONE;
        end else if (host_rd_ready_q && host_rd_valid) begin
          sd_buff_dout_d = host_rd_data;
          sd_buff_addr_d = cnt_q[ADDR_W-1:0];
          sd_buff_wr_d   = 1'b1;
          cnt_d          = cnt_q + CNT_W'(1);
        end else begin
          state_d = ST_RD_DATA;
        end
      end
      ST_WR_ADDR: begin
        state_d = ST_WR_CAP;
      end
      ST_WR_CAP: begin
        host_wr_data_d = sd_buff_din;
        state_d        = ST_WR_SEND;
      end
      ST_WR_SEND: begin
        if (host_wr_valid_q && host_wr_ready) begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = cnt_d[ADDR_W] ? ST_DONE : ST_WR_ADDR;
        end else begin
          state_d = ST_WR_SEND;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // The buffer address for a write byte is presented during WR_ADDR.
    if (state_d == ST_WR_ADDR) begin
      sd_buff_addr_d = cnt_d[ADDR_W-1:0];
    end else begin
      sd_buff_addr_d = sd_buff_addr_d;
    end

    sd_ack_d         = sd_state_active(state_d);
    host_cmd_valid_d = (state_d == ST_CMD);
    host_rd_ready_d  = (state_d == ST_RD_DATA) && !cnt_d[ADDR_W];
    host_wr_valid_d  = (state_d == ST_WR_SEND);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      cnt_q            <= '0;
      sd_ack_q         <= 1'b0;
      sd_buff_addr_q   <= '0;
      sd_buff_dout_q   <= 8'h00;
      sd_buff_wr_q     <= 1'b0;
      host_cmd_valid_q <= 1'b0;
      host_cmd_lba_q   <= 32'h0000_0000;
      host_cmd_write_q <= 1'b0;
      host_rd_ready_q  <= 1'b0;
      host_wr_valid_q  <= 1'b0;
      host_wr_data_q   <= 8'h00;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      sd_ack_q         <= sd_ack_d;
      sd_buff_addr_q   <= sd_buff_addr_d;
      sd_buff_dout_q   <= sd_buff_dout_d;
      sd_buff_wr_q     <= sd_buff_wr_d;
      host_cmd_valid_q <= host_cmd_valid_d;
      host_cmd_lba_q   <= host_cmd_lba_d;
      host_cmd_write_q <= host_cmd_write_d;
      host_rd_ready_q  <= host_rd_ready_d;
      host_wr_valid_q  <= host_wr_valid_d;
      host_wr_data_q   <= host_wr_data_d;
    end
  end

  assign sd_ack         = sd_ack_q;
  assign sd_buff_addr   = sd_buff_addr_q;
  assign sd_buff_dout   = sd_buff_dout_q;
  assign sd_buff_wr     = sd_buff_wr_q;
  assign host_cmd_valid = host_cmd_valid_q;
  assign host_cmd_lba   = host_cmd_lba_q;
  assign host_cmd_write = host_cmd_write_q;
  assign host_rd_ready  = host_rd_ready_q;
  assign host_wr_valid  = host_wr_valid_q;
  assign host_wr_data   = host_wr_data_q;

endmodule
